// File: rtl/riscv_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the zero-latency instruction
// memory combinationally, and registers the returned word into IF/ID.
// Handles decode stall, execute redirect (with flush), and a sticky
// out-of-range fetch fault that only reset or a redirect can clear.
module riscv_fetch_stage #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int          IMEM_ADDR_BITS = 10,
    parameter logic [31:0] NOP_INSTR      = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc,
    output logic        ifid_valid,
    output logic        fetch_fault,
    output logic [31:0] fault_pc
);

    typedef enum logic {ST_RUN, ST_FAULT} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] ipc_q, ipc_d;
    logic [31:0] fpc_q, fpc_d;
    logic        valid_q, valid_d;
    logic        fault_q, fault_d;

    logic [31:0] tgt_pc;
    logic        in_range;
    logic        tgt_in_range;

    // Redirect targets are forced word-aligned; misaligned low bits are dropped.
    assign tgt_pc       = redirect_pc & ~32'h3;
    assign in_range     = (pc_q[31:IMEM_ADDR_BITS] == '0);
    assign tgt_in_range = (tgt_pc[31:IMEM_ADDR_BITS] == '0);

    assign imem_addr   = pc_q;
    assign ifid_instr  = instr_q;
    assign ifid_pc     = ipc_q;
    assign ifid_valid  = valid_q;
    assign fetch_fault = fault_q;
    assign fault_pc    = fpc_q;

    // State register for the RUN/FAULT machine.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_RUN;
        else        state_q <= state_d;
    end

    // Next-state and next-datapath values; everything holds unless changed.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        valid_d = valid_q;
        fault_d = fault_q;
        fpc_d   = fpc_q;
        case (state_q)
            ST_RUN: begin
                if (redirect_valid) begin
                    // Redirect wins over stall and flushes IF/ID.
                    pc_d    = tgt_pc;
                    instr_d = NOP_INSTR;
                    valid_d = 1'b0;
                    ipc_d   = '0;
                end else if (stall) begin
                    // hold everything
                end else if (!in_range) begin
                    state_d = ST_FAULT;
                    fault_d = 1'b1;
                    fpc_d   = pc_q;
                    valid_d = 1'b0;
                    instr_d = NOP_INSTR;
                end else begin
                    instr_d = imem_instr;
                    ipc_d   = pc_q;
                    valid_d = 1'b1;
                    pc_d    = pc_q + 32'd4;
                end
            end
            ST_FAULT: begin
                // pc holds while faulted, so this tracks the faulting PC and
                // picks up an out-of-range redirect target one cycle later.
                fpc_d   = pc_q;
                valid_d = 1'b0;
                if (redirect_valid) begin
                    pc_d    = tgt_pc;
                    instr_d = NOP_INSTR;
                    ipc_d   = '0;
                    if (tgt_in_range) begin
                        state_d = ST_RUN;
                        fault_d = 1'b0;
                    end
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // PC, IF/ID and fault registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            ipc_q   <= '0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            fpc_q   <= '0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
            fpc_q   <= fpc_d;
        end
    end

endmodule

// File: tb/tb_riscv_fetch_stage.sv
// Bench for riscv_fetch_stage: directed stimulus with literal checks plus a
// spec-level model compared against every output on every falling edge.
module tb_riscv_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc;
    logic        ifid_valid;
    logic        fetch_fault;
    logic [31:0] fault_pc;

    logic [31:0] mem [0:255];

    int total = 0;
    int bad   = 0;

    riscv_fetch_stage dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_addr(imem_addr), .imem_instr(imem_instr),
        .ifid_instr(ifid_instr), .ifid_pc(ifid_pc), .ifid_valid(ifid_valid),
        .fetch_fault(fetch_fault), .fault_pc(fault_pc)
    );

    always #5 clk = ~clk;

    // Zero-latency instruction memory, 1 KB.
    assign imem_instr = (imem_addr < 32'h400) ? mem[imem_addr[9:2]] : 32'hDEAD_BEEF;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Behavioural model: PC/IF-ID/fault contents from the priority rules.
    logic        armed = 1'b0;
    logic [31:0] m_pc, m_instr, m_ipc, m_fpc;
    logic        m_valid, m_fault;

    always @(posedge clk) begin
        if (!rst_n) begin
            armed = 1'b1;
            m_pc = 32'h0; m_instr = NOP; m_ipc = 32'h0; m_valid = 1'b0;
            m_fault = 1'b0; m_fpc = 32'h0;
        end else if (armed) begin
            if (redirect_valid) begin
                m_pc = redirect_pc & ~32'h3;
                m_instr = NOP; m_valid = 1'b0; m_ipc = 32'h0;
                if (m_fault) m_fault = (m_pc >= 32'h400);
            end else if (m_fault) begin
                m_fpc = m_pc;
            end else if (stall) begin
                m_pc = m_pc;
            end else if (m_pc >= 32'h400) begin
                m_fault = 1'b1; m_fpc = m_pc; m_valid = 1'b0; m_instr = NOP;
            end else begin
                m_instr = mem[m_pc[9:2]]; m_ipc = m_pc; m_valid = 1'b1;
                m_pc = m_pc + 32'd4;
            end
        end
    end

    // Compare every output with the model away from the active edge.
    always @(negedge clk) begin
        if (armed) begin
            chk("m_imem_addr", imem_addr, m_pc);
            chk("m_ifid_instr", ifid_instr, m_instr);
            chk("m_ifid_pc", ifid_pc, m_ipc);
            chk("m_ifid_valid", {31'b0, ifid_valid}, {31'b0, m_valid});
            chk("m_fetch_fault", {31'b0, fetch_fault}, {31'b0, m_fault});
            chk("m_fault_pc", fault_pc, m_fpc);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic ifid(input string nm, input logic [31:0] pc, input logic [31:0] ins,
                        input logic v, input logic [31:0] addr);
        chk({nm, "_pc"}, ifid_pc, pc);
        chk({nm, "_instr"}, ifid_instr, ins);
        chk({nm, "_valid"}, {31'b0, ifid_valid}, {31'b0, v});
        chk({nm, "_addr"}, imem_addr, addr);
    endtask

    task automatic flt(input string nm, input logic f, input logic [31:0] fpc);
        chk({nm, "_fault"}, {31'b0, fetch_fault}, {31'b0, f});
        chk({nm, "_fpc"}, fault_pc, fpc);
    endtask

    task automatic redir(input logic [31:0] tgt, input logic st);
        redirect_valid = 1'b1; redirect_pc = tgt; stall = st;
        cyc();
        redirect_valid = 1'b0; redirect_pc = 32'h0; stall = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE_0000 | i;
        mem[0] = 32'h1111_1111; mem[1] = 32'h2222_2222;
        mem[2] = 32'h3333_3333; mem[3] = 32'h4444_4444;
        rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        cyc(); cyc();
        ifid("rst", 32'h0, NOP, 1'b0, 32'h0);
        flt("rst", 1'b0, 32'h0);

        // sequential fetch
        rst_n = 1'b1;
        cyc(); ifid("seq0", 32'h0, 32'h1111_1111, 1'b1, 32'h4);
        cyc(); ifid("seq1", 32'h4, 32'h2222_2222, 1'b1, 32'h8);

        // stall three cycles
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(); ifid("stall", 32'h4, 32'h2222_2222, 1'b1, 32'h8);
        end
        stall = 1'b0;
        cyc(); ifid("unstall", 32'h8, 32'h3333_3333, 1'b1, 32'hC);

        // redirect overriding stall, misaligned target
        redir(32'h41, 1'b1);
        ifid("redir_bubble", 32'h0, NOP, 1'b0, 32'h40);
        cyc(); ifid("redir_tgt", 32'h40, 32'hC0DE_0010, 1'b1, 32'h44);

        // range fault at the top of memory
        redir(32'h3FC, 1'b0);
        ifid("top_bubble", 32'h0, NOP, 1'b0, 32'h3FC);
        cyc(); ifid("top_word", 32'h3FC, 32'hC0DE_00FF, 1'b1, 32'h400);
        cyc(); ifid("fault_ent", 32'h3FC, NOP, 1'b0, 32'h400);
        flt("fault_ent", 1'b1, 32'h400);
        for (int i = 0; i < 5; i++) begin
            stall = i[0];
            cyc(); ifid("fault_hold", 32'h3FC, NOP, 1'b0, 32'h400);
            flt("fault_hold", 1'b1, 32'h400);
        end
        stall = 1'b0;

        // recovery with in-range redirect
        redir(32'h20, 1'b0);
        flt("recov", 1'b0, 32'h400);
        ifid("recov", 32'h0, NOP, 1'b0, 32'h20);
        cyc(); ifid("recov_tgt", 32'h20, 32'hC0DE_0008, 1'b1, 32'h24);

        // fault again, then redirect out of range
        redir(32'h3FC, 1'b0);
        cyc(); cyc();
        flt("fault2", 1'b1, 32'h400);
        redir(32'h800, 1'b0);
        flt("oor_redir", 1'b1, 32'h400);
        chk("oor_addr", imem_addr, 32'h800);
        cyc(); flt("oor_fpc", 1'b1, 32'h800);

        // leave fault at 0x30, stall, then reset mid-run
        redir(32'h30, 1'b0);
        flt("to30", 1'b0, 32'h800);
        stall = 1'b1;
        cyc(); chk("stall30_addr", imem_addr, 32'h30);
        rst_n = 1'b0;
        cyc(); ifid("midrst", 32'h0, NOP, 1'b0, 32'h0);
        flt("midrst", 1'b0, 32'h0);
        rst_n = 1'b1; stall = 1'b0;
        cyc(); ifid("after_rst", 32'h0, 32'h1111_1111, 1'b1, 32'h4);
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/riscv_fetch_stage.md
Name: riscv_fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the instruction memory.
- Owns the program counter and drives the word-aligned fetch address combinationally to the instruction memory.
- Captures the returned instruction into an IF/ID pipeline register with a valid bit.
- Handles decode-stage stall, execute-stage branch/jump redirect with flush, and out-of-range fetch faults.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- IMEM_ADDR_BITS, 10, byte-address width covered by instruction memory (256 words = 1 KB).
- NOP_INSTR, 32'h0000_0013, ADDI x0,x0,0 placed in the IF/ID register when it is empty or flushed.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- stall  input  1  decode requests hold; PC and IF/ID keep their values.
- redirect_valid  input  1  taken branch/jump from execute.
- redirect_pc  input  32  target byte address for the redirect.
- imem_addr  output  32  fetch byte address to instruction memory; equals pc (combinational).
- imem_instr  input  32  instruction word returned combinationally for imem_addr.
- ifid_instr  output  32  registered instruction to decode.
- ifid_pc  output  32  registered PC of ifid_instr.
- ifid_valid  output  1  ifid_instr is a real fetched instruction.
- fetch_fault  output  1  sticky; set when fetch leaves the memory range.
- fault_pc  output  32  PC that caused the fault.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - pc=RESET_PC, ifid_instr=NOP_INSTR, ifid_pc=0, ifid_valid=0.
  - fetch_fault=0, fault_pc=0, state=RUN.
  - Reset mid-operation discards any pending redirect or stall.
- imem_addr = pc at all times, with no register in between. Instruction memory is zero-latency, so imem_instr is used in the same cycle.
- Range check: in_range = (pc[31:IMEM_ADDR_BITS] == 0).
- States: RUN and FAULT. Priority within RUN, evaluated each rising edge:
  1. redirect_valid=1, regardless of stall:
     - pc <= {redirect_pc[31:2], 2'b00}; misaligned low bits are silently dropped.
     - ifid_instr <= NOP_INSTR, ifid_valid <= 0, ifid_pc <= 0.
     - Redirect overrides stall.
  2. stall=1: pc, ifid_instr, ifid_pc and ifid_valid all hold.
  3. in_range=0:
     - state <= FAULT, fetch_fault <= 1, fault_pc <= pc.
     - ifid_valid <= 0, ifid_instr <= NOP_INSTR; pc holds.
  4. Otherwise:
     - ifid_instr <= imem_instr, ifid_pc <= pc, ifid_valid <= 1.
     - pc <= pc + 4 (32-bit modulo add).
- FAULT:
  - pc, fault_pc and fetch_fault hold; ifid_valid=0; stall has no effect.
  - redirect_valid=1 with an in-range target returns to RUN, clears fetch_fault and applies the redirect exactly as in RUN.
  - A redirect to an out-of-range target loads pc, stays in FAULT and updates fault_pc to the new pc on the following cycle.
  - Only reset or a redirect clears FAULT.
- Latency: the instruction at pc appears on ifid_instr one cycle after pc is presented. After a redirect there is one bubble cycle (ifid_valid=0), and the target instruction is valid on the second edge.
- Boundary: last word pc=0x3FC is fetched normally; the next cycle has pc=0x400, which faults with fault_pc=0x400.
- The first edge after reset release loads IF/ID with the RESET_PC instruction; ifid_valid is 0 in the cycle after reset only.

Test Plan:
- Sequential fetch: reset, memory words 0..3 = 11111111, 22222222, 33333333, 44444444.
  - Required: ifid_pc = 0, 4, 8, C on consecutive cycles with matching ifid_instr, ifid_valid=1.
  - Required: imem_addr leads ifid_pc by 4.
- Stall: stall=1 for 3 cycles while ifid_pc=4.
  - Required: ifid_pc=4, ifid_instr=22222222 and imem_addr=8 held.
  - Required: after release, ifid_pc=8 next cycle.
- Redirect with stall: at pc=0xC, assert redirect_valid=1, redirect_pc=0x41 and stall=1 together.
  - Required: next cycle ifid_valid=0, ifid_instr=00000013, imem_addr=0x40.
  - Required: following cycle ifid_pc=0x40, valid=1.
- Range fault: redirect to 0x3FC.
  - Required: ifid_pc=0x3FC valid, then fetch_fault=1, fault_pc=0x400, ifid_valid=0.
  - Required: all outputs held for 5 cycles even with stall toggling.
- Fault recovery: in FAULT, redirect to 0x20.
  - Required: fetch_fault=0 on the next cycle, ifid_pc=0x20 valid on the cycle after.
  - Required: a redirect to 0x800 instead keeps fetch_fault=1 and sets fault_pc=0x800.
- Mid-run reset: rst_n=0 for one edge while at pc=0x30 with stall=1.
  - Required: pc=0, ifid_valid=0, ifid_instr=00000013, fetch_fault=0.
  - Required: ifid_pc=0 valid on the next edge.
